quadrature_encoder: RTL and testbench
=====================================

QUADRATURE_ENCODER -- requirements
Module: quadrature_encoder

Interface
REQ-001 SHALL have parameter STEP_WIDTH, default 16, width of cmd_steps and remaining-step counter.
REQ-002 SHALL have parameter DIV_WIDTH, default 16, width of cmd_period and edge-timing counter.
REQ-003 SHALL have parameter POS_WIDTH, default 32, width of signed position output.
REQ-004 SHALL have parameter CPR, default 96, edges per revolution, used only for the index output.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port cmd_valid  input  1  command offered.
REQ-008 SHALL have port cmd_ready  output  1  block idle and able to accept a command.
REQ-009 SHALL have port cmd_dir  input  1  1 = CW (A leads B), 0 = CCW.
REQ-010 SHALL have port cmd_steps  input  STEP_WIDTH  number of quadrature edges to emit.
REQ-011 SHALL have port cmd_period  input  DIV_WIDTH  clocks between edges; 0 treated as 1.
REQ-012 SHALL have port cmd_abort  input  1  stop the current command.
REQ-013 SHALL have port phase_a  output  1  encoder channel A.
REQ-014 SHALL have port phase_b  output  1  encoder channel B.
REQ-015 SHALL have port busy  output  1  high in RUN state.
REQ-016 SHALL have port done  output  1  one-cycle pulse at command completion or abort.
REQ-017 SHALL have port position  output  POS_WIDTH  signed net edge count, two's complement.

Function
REQ-018 SHALL implement states IDLE and RUN; cmd_ready = (state == IDLE), busy = (state == RUN).
REQ-019 SHALL accept a command on a cycle with cmd_valid & cmd_ready, latching dir, steps and period (0 replaced by 1).
REQ-020 SHALL, on accepting cmd_steps = 0, stay in IDLE, emit no edge and pulse done on the next cycle.
REQ-021 SHALL, on accepting cmd_steps > 0, enter RUN with the edge counter cleared.
REQ-022 SHALL, in RUN, emit one edge every period clocks; the first edge appears period cycles after the acceptance cycle.
REQ-023 SHALL step (A,B) through Gray sequence 00,10,11,01,00 when CW and through the reverse when CCW; exactly one channel toggles per edge.
REQ-024 SHALL increment position per CW edge and decrement it per CCW edge, wrapping modulo 2^POS_WIDTH.
REQ-025 SHALL, on the final edge, pulse done in that same cycle and return to IDLE.
REQ-026 SHALL, on cmd_abort in RUN, return to IDLE next cycle, pulse done, hold phase and position, and suppress any edge due that cycle.
REQ-027 SHALL ignore cmd_abort in IDLE and ignore cmd_valid while in RUN.
REQ-028 SHALL hold phase_a/phase_b across commands so a new command continues from the current Gray state.
REQ-029 SHALL register all outputs with no combinational path from inputs except none to phase/position.

Reset
REQ-030 SHALL, when rst = 0 at a clock edge, force IDLE, phase_a = 0, phase_b = 0, position = 0, done = 0, busy = 0, cmd_ready = 1, and clear counters, including mid-command.

Configuration
REQ-031 SHALL, with QUAD_ENC_INDEX_EN defined, add output index (1 bit), high while the revolution counter equals 0; this counter tracks position modulo CPR (increments/decrements with wrap 0..CPR-1) and is 0 after reset.
REQ-032 SHALL, without QUAD_ENC_INDEX_EN, have no index port and no revolution counter.

Verification
REQ-033 SHALL cover: reset, CW steps=4 period=3 -> (A,B) 10,11,01,00 at cycles 3,6,9,12 after accept, position=4, done at edge 4.
REQ-034 SHALL cover: CCW steps=2 period=1 from 00 -> 01 then 11 on consecutive cycles, position=-2 (0xFFFFFFFE).
REQ-035 SHALL cover: steps=0 -> no phase change, done pulse one cycle after accept, cmd_ready stays 1.
REQ-036 SHALL cover: CW steps=10 period=5, abort on cycle 5 after accept -> no edge that cycle, position=0, done pulse, IDLE.
REQ-037 SHALL cover: rst low during RUN with position=3 -> next cycle A=B=0, position=0, busy=0, cmd_ready=1.
REQ-038 SHALL cover (QUAD_ENC_INDEX_EN, CPR=4): CW steps=5 period=1 -> index high at reset, low for edges 1-3, high after edge 4, low after edge 5.

Source files
------------

// File: rtl/quadrature_encoder.sv
// quadrature_encoder
//   Emits a commanded number of quadrature edges on phase_a/phase_b at a
//   programmable rate and tracks the signed net edge count.
//
//   Parameters:
//     STEP_WIDTH  width of cmd_steps and the remaining-edge counter
//     DIV_WIDTH   width of cmd_period and the edge-timing counter
//     POS_WIDTH   width of the signed position output
//     CPR         edges per revolution (index output only)
//
//   Ports:
//     clk         clock, all logic on rising edge
//     rst         synchronous active-low reset
//     cmd_valid   command offered; accepted when cmd_ready is high
//     cmd_ready   idle and able to accept a command
//     cmd_dir     1 = CW (A leads B), 0 = CCW
//     cmd_steps   number of edges to emit (0 = immediate done)
//     cmd_period  clocks between edges (0 treated as 1)
//     cmd_abort   stop the running command
//     phase_a/b   encoder channels
//     busy        command running
//     done        one-cycle pulse at completion or abort
//     position    signed net edge count (two's complement, wrapping)
//     index       only with QUAD_ENC_INDEX_EN: high while position mod CPR == 0
//
//   Build option: define QUAD_ENC_INDEX_EN to add the index output and the
//   revolution counter behind it.
module quadrature_encoder #(
    parameter int unsigned STEP_WIDTH = 16,
    parameter int unsigned DIV_WIDTH  = 16,
    parameter int unsigned POS_WIDTH  = 32,
    parameter int unsigned CPR        = 96
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_dir,
    input  logic [STEP_WIDTH-1:0]       cmd_steps,
    input  logic [DIV_WIDTH-1:0]        cmd_period,
    input  logic                        cmd_abort,
    output logic                        phase_a,
    output logic                        phase_b,
    output logic                        busy,
    output logic                        done,
    output logic signed [POS_WIDTH-1:0] position
`ifdef QUAD_ENC_INDEX_EN
    ,
    output logic                        index
`endif
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [DIV_WIDTH-1:0]  DIV_ONE  = DIV_WIDTH'(1);
    localparam logic [STEP_WIDTH-1:0] STEP_ONE = STEP_WIDTH'(1);
    localparam logic [POS_WIDTH-1:0]  POS_ONE  = POS_WIDTH'(1);

    logic [0:0]            state_q,  state_d;
    logic                  dir_q,    dir_d;
    logic [STEP_WIDTH-1:0] rem_q,    rem_d;
    logic [DIV_WIDTH-1:0]  period_q, period_d;
    logic [DIV_WIDTH-1:0]  div_q,    div_d;
    logic                  a_q,      a_d;
    logic                  b_q,      b_d;
    logic [POS_WIDTH-1:0]  pos_q,    pos_d;
    logic                  done_q,   done_d;
    logic                  edge_fire;

`ifdef QUAD_ENC_INDEX_EN
    localparam int unsigned REV_W = (CPR > 1) ? $clog2(CPR) : 1;
    localparam logic [REV_W-1:0] REV_MAX = REV_W'(CPR - 1);
    localparam logic [REV_W-1:0] REV_ONE = REV_W'(1);

    logic [REV_W-1:0] rev_q, rev_d;
    logic             index_q, index_d;
`endif

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        rem_d     = rem_q;
        period_d  = period_q;
        div_d     = div_q;
        a_d       = a_q;
        b_d       = b_q;
        pos_d     = pos_q;
        done_d    = 1'b0;
        edge_fire = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    dir_d    = cmd_dir;
                    rem_d    = cmd_steps;
                    period_d = (cmd_period == '0) ? DIV_ONE : cmd_period;
                    div_d    = '0;
                    if (cmd_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            default: begin
                // Abort takes priority so an edge due this cycle is dropped.
                if (cmd_abort) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (div_q == period_q - DIV_ONE) begin
                    edge_fire = 1'b1;
                    div_d     = '0;
                    rem_d     = rem_q - STEP_ONE;
                    if (rem_q == STEP_ONE) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
        endcase

        // Gray walk: CW toggles A when A==B else B (00,10,11,01);
        // CCW toggles the other channel (00,01,11,10).
        if (edge_fire) begin
            if ((a_q == b_q) == dir_q) begin
                a_d = ~a_q;
            end else begin
                b_d = ~b_q;
            end
            pos_d = dir_q ? (pos_q + POS_ONE) : (pos_q - POS_ONE);
        end
    end

`ifdef QUAD_ENC_INDEX_EN
    always_comb begin
        rev_d = rev_q;
        if (edge_fire) begin
            if (dir_q) begin
                rev_d = (rev_q == REV_MAX) ? '0 : (rev_q + REV_ONE);
            end else begin
                rev_d = (rev_q == '0) ? REV_MAX : (rev_q - REV_ONE);
            end
        end
        index_d = (rev_d == '0);
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            dir_q    <= 1'b0;
            rem_q    <= '0;
            period_q <= DIV_ONE;
            div_q    <= '0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            pos_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            rem_q    <= rem_d;
            period_q <= period_d;
            div_q    <= div_d;
            a_q      <= a_d;
            b_q      <= b_d;
            pos_q    <= pos_d;
            done_q   <= done_d;
        end
    end

`ifdef QUAD_ENC_INDEX_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            rev_q   <= '0;
            index_q <= 1'b1;
        end else begin
            rev_q   <= rev_d;
            index_q <= index_d;
        end
    end

    assign index = index_q;
`endif

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_RUN);
    assign phase_a   = a_q;
    assign phase_b   = b_q;
    assign done      = done_q;
    assign position  = pos_q;

endmodule

// File: tb/tb_quadrature_encoder.sv
module tb_quadrature_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic [15:0] cmd_steps;
    logic [15:0] cmd_period;
    logic        cmd_abort;
    logic        phase_a;
    logic        phase_b;
    logic        busy;
    logic        done;
    logic signed [31:0] position;
`ifdef QUAD_ENC_INDEX_EN
    logic        index;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    quadrature_encoder #(
        .STEP_WIDTH(16),
        .DIV_WIDTH (16),
        .POS_WIDTH (32),
`ifdef QUAD_ENC_INDEX_EN
        .CPR       (4)
`else
        .CPR       (96)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_steps (cmd_steps),
        .cmd_period(cmd_period),
        .cmd_abort (cmd_abort),
        .phase_a   (phase_a),
        .phase_b   (phase_b),
        .busy      (busy),
        .done      (done),
        .position  (position)
`ifdef QUAD_ENC_INDEX_EN
        ,
        .index     (index)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle at the falling edge where inputs are driven
    // and outputs sampled.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    // Present a command for exactly one rising edge (the accept edge).
    task automatic issue(input logic dir, input logic [15:0] steps, input logic [15:0] period);
        cmd_valid  = 1'b1;
        cmd_dir    = dir;
        cmd_steps  = steps;
        cmd_period = period;
        step();
        cmd_valid  = 1'b0;
    endtask

    logic [1:0] cw_seq [0:4];

    initial begin
        cw_seq[0] = 2'b00;
        cw_seq[1] = 2'b10;
        cw_seq[2] = 2'b11;
        cw_seq[3] = 2'b01;
        cw_seq[4] = 2'b00;

        cmd_valid  = 1'b0;
        cmd_dir    = 1'b0;
        cmd_steps  = '0;
        cmd_period = '0;
        cmd_abort  = 1'b0;
        rst        = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset state
        chk("rst_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_done",  64'(done), 64'd0);
        chk("rst_ab",    64'({phase_a, phase_b}), 64'd0);
        chk("rst_pos",   64'(unsigned'(position)), 64'd0);
`ifdef QUAD_ENC_INDEX_EN
        chk("rst_index", 64'(index), 64'd1);
`endif

        // Abort while idle is ignored
        cmd_abort = 1'b1;
        step();
        cmd_abort = 1'b0;
        chk("idle_abort_done",  64'(done), 64'd0);
        chk("idle_abort_ready", 64'(cmd_ready), 64'd1);

        // CW steps=4 period=3: edges at cycles 3,6,9,12 after accept
        issue(1'b1, 16'd4, 16'd3);
        chk("cw_busy0",  64'(busy), 64'd1);
        chk("cw_ready0", 64'(cmd_ready), 64'd0);
        chk("cw_ab0",    64'({phase_a, phase_b}), 64'd0);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("cw_ab%0d", k), 64'({phase_a, phase_b}), 64'(cw_seq[k / 3]));
            chk($sformatf("cw_done%0d", k), 64'(done), (k == 12) ? 64'd1 : 64'd0);
        end
        chk("cw_pos",   64'(unsigned'(position)), 64'd4);
        chk("cw_busy",  64'(busy), 64'd0);
        chk("cw_ready", 64'(cmd_ready), 64'd1);
        step();
        chk("cw_done_clr", 64'(done), 64'd0);

        // CCW steps=2 period=1 from 00
        do_reset();
        issue(1'b0, 16'd2, 16'd1);
        step();
        chk("ccw_ab1",   64'({phase_a, phase_b}), 64'b01);
        chk("ccw_pos1",  64'(unsigned'(position)), 64'hFFFF_FFFF);
        chk("ccw_done1", 64'(done), 64'd0);
        step();
        chk("ccw_ab2",   64'({phase_a, phase_b}), 64'b11);
        chk("ccw_pos2",  64'(unsigned'(position)), 64'hFFFF_FFFE);
        chk("ccw_done2", 64'(done), 64'd1);
        chk("ccw_ready", 64'(cmd_ready), 64'd1);

        // steps=0: immediate done, phase held at 11
        step();
        issue(1'b1, 16'd0, 16'd7);
        chk("zero_done",  64'(done), 64'd1);
        chk("zero_ready", 64'(cmd_ready), 64'd1);
        chk("zero_busy",  64'(busy), 64'd0);
        chk("zero_ab",    64'({phase_a, phase_b}), 64'b11);
        step();
        chk("zero_done_clr", 64'(done), 64'd0);
        chk("zero_pos", 64'(unsigned'(position)), 64'hFFFF_FFFE);

        // CW steps=10 period=5, abort sampled on cycle 5 after accept
        do_reset();
        issue(1'b1, 16'd10, 16'd5);
        for (int k = 1; k <= 4; k++) step();
        chk("abort_pre_ab", 64'({phase_a, phase_b}), 64'd0);
        chk("abort_pre_busy", 64'(busy), 64'd1);
        cmd_abort = 1'b1;
        step();
        cmd_abort = 1'b0;
        chk("abort_ab",    64'({phase_a, phase_b}), 64'd0);
        chk("abort_pos",   64'(unsigned'(position)), 64'd0);
        chk("abort_done",  64'(done), 64'd1);
        chk("abort_busy",  64'(busy), 64'd0);
        chk("abort_ready", 64'(cmd_ready), 64'd1);
        step();
        chk("abort_done_clr", 64'(done), 64'd0);

        // period=0 behaves as 1
        issue(1'b1, 16'd1, 16'd0);
        step();
        chk("p0_ab",   64'({phase_a, phase_b}), 64'b10);
        chk("p0_pos",  64'(unsigned'(position)), 64'd1);
        chk("p0_done", 64'(done), 64'd1);

        // Reset during RUN with position=3; cmd_valid in RUN ignored
        do_reset();
        issue(1'b1, 16'd5, 16'd1);
        cmd_valid = 1'b1;
        cmd_steps = 16'd0;
        step();
        step();
        step();
        cmd_valid = 1'b0;
        chk("run_ignore_done", 64'(done), 64'd0);
        chk("mid_ab",  64'({phase_a, phase_b}), 64'b01);
        chk("mid_pos", 64'(unsigned'(position)), 64'd3);
        rst = 1'b0;
        step();
        chk("midrst_ab",    64'({phase_a, phase_b}), 64'd0);
        chk("midrst_pos",   64'(unsigned'(position)), 64'd0);
        chk("midrst_busy",  64'(busy), 64'd0);
        chk("midrst_ready", 64'(cmd_ready), 64'd1);
        rst = 1'b1;
        step();
        chk("midrst_stay_idle", 64'(busy), 64'd0);

`ifdef QUAD_ENC_INDEX_EN
        // CPR=4: index high at 0, low for edges 1-3, high at 4, low at 5
        do_reset();
        chk("idx_rst", 64'(index), 64'd1);
        issue(1'b1, 16'd5, 16'd1);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("idx_e%0d", k), 64'(index), (k == 4) ? 64'd1 : 64'd0);
        end
        chk("idx_pos", 64'(unsigned'(position)), 64'd5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
